mii_tx_framer: RTL

- Upstream neighbour of the 64-bit MII TX checker.
- Takes frame payload as a 64-bit valid/ready word stream with byte keep and last.
- Produces the 64-bit data + 8-bit control TX lane stream: a start word carrying START, preamble and SFD; the data words; a TERM code in the lane after the last valid byte; IDLE fill; and a minimum inter-packet gap before the next start.
- Underrun mid-frame is signalled on the line with ERROR codes.

---
 rtl/mii_tx_framer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mii_tx_framer.sv
// ---------------------------------------------------------------------------
// mii_tx_framer
//
// Turns a 64-bit valid/ready payload stream (byte keep + last) into the
// 64-bit data / 8-bit control TX lane stream: a start word (START, preamble,
// SFD), the payload words, TERM in the lane after the last valid byte, IDLE
// fill, and a minimum inter-packet gap before the next start. A source
// underrun mid-frame puts an all-ERROR word on the line and the rest of the
// frame is drained without being transmitted.
//
// Ports
//   clk            single clock
//   i_rst          synchronous active-high reset
//   i_s_data       payload word, lane k = bits [8k+7:8k], first byte in lane 0
//   i_s_keep       valid lanes, all ones except on the last word
//   i_s_valid      source word valid
//   i_s_last       last word of the frame
//   o_s_ready      word accepted when i_s_valid & o_s_ready
//   o_tx_data      TX lane data (registered)
//   o_tx_ctrl      TX lane control, 1 = control character (registered)
//   o_frame_done   one-cycle pulse on the cycle carrying TERM
//   o_frame_bytes  payload byte count of the last completed frame
//   o_underrun     one-cycle pulse on the cycle carrying the ERROR word
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | emitting idle words, waiting for valid and the inter-packet gap
// DATA  | forwarding payload words, closing the frame on last
// TERM  | last word was full, TERM goes in lane 0 of this extra word
// DRAIN | after an underrun, discarding source words up to last
// ---------------------------------------------------------------------------
module mii_tx_framer #(
    parameter int         DATA_WIDTH = 64,
    parameter int         CTRL_WIDTH = 8,
    parameter logic [7:0] IDLE_CODE  = 8'h07,
    parameter logic [7:0] START_CODE = 8'hFB,
    parameter logic [7:0] TERM_CODE  = 8'hFD,
    parameter logic [7:0] ERROR_CODE = 8'hFE,
    parameter int         P_MIN_IPG  = 12
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    input  logic [CTRL_WIDTH-1:0] i_s_keep,
    input  logic                  i_s_valid,
    input  logic                  i_s_last,
    output logic                  o_s_ready,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
    output logic                  o_frame_done,
    output logic [15:0]           o_frame_bytes,
    output logic                  o_underrun
);

    localparam int LANES = CTRL_WIDTH;
    localparam int KW    = $clog2(LANES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_TERM  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [7:0]  MIN_IPG   = 8'(P_MIN_IPG);
    localparam logic [7:0]  IDLE_STEP = 8'(LANES);
    localparam logic [7:0]  IDLE_TAIL = 8'(LANES - 1);
    localparam logic [15:0] BYTE_STEP = 16'(LANES);

    localparam logic [DATA_WIDTH-1:0] IDLE_WORD  = {LANES{IDLE_CODE}};
    localparam logic [DATA_WIDTH-1:0] ERROR_WORD = {LANES{ERROR_CODE}};
    localparam logic [DATA_WIDTH-1:0] START_WORD = {8'hD5, {(LANES-2){8'h55}}, START_CODE};
    localparam logic [DATA_WIDTH-1:0] TERM_WORD  = {{(LANES-1){IDLE_CODE}}, TERM_CODE};
    localparam logic [CTRL_WIDTH-1:0] CTRL_ALL   = '1;
    localparam logic [CTRL_WIDTH-1:0] CTRL_NONE  = '0;
    localparam logic [CTRL_WIDTH-1:0] START_CTRL = {{(LANES-1){1'b0}}, 1'b1};

    logic [1:0]            state;
    logic [7:0]            idle_cnt;
    logic [15:0]           byte_cnt;

    logic [1:0]            state_nxt;
    logic [7:0]            idle_nxt;
    logic [15:0]           byte_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [CTRL_WIDTH-1:0] ctrl_nxt;
    logic                  done_nxt;
    logic                  underrun_nxt;
    logic [15:0]           bytes_nxt;

    logic [KW-1:0]         keep_n;
    logic                  run_open;
    logic [DATA_WIDTH-1:0] term_data;
    logic [CTRL_WIDTH-1:0] term_ctrl;
    logic [7:0]            idle_step;
    logic [15:0]           byte_step;
    logic [16:0]           bytes_sum;
    logic [15:0]           bytes_last;

    assign o_s_ready = (state == ST_DATA) || (state == ST_DRAIN);

    // Length of the run of ones from lane 0; anything past the first zero
    // is not payload, even if its keep bit is set.
    always_comb begin
        keep_n   = '0;
        run_open = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            if (run_open && i_s_keep[k]) begin
                keep_n = keep_n + KW'(1);
            end else begin
                run_open = 1'b0;
            end
        end
    end

    // Closing word for a short last word: payload, TERM, then IDLE fill.
    always_comb begin
        term_data = IDLE_WORD;
        term_ctrl = CTRL_ALL;
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(keep_n)) begin
                term_data[8*k +: 8] = i_s_data[8*k +: 8];
                term_ctrl[k]        = 1'b0;
            end else if (k == int'(keep_n)) begin
                term_data[8*k +: 8] = TERM_CODE;
            end
        end
    end

    assign idle_step  = (idle_cnt > (8'hFF - IDLE_STEP)) ? 8'hFF : idle_cnt + IDLE_STEP;
    assign byte_step  = (byte_cnt > (16'hFFFF - BYTE_STEP)) ? 16'hFFFF : byte_cnt + BYTE_STEP;
    assign bytes_sum  = {1'b0, byte_cnt} + 17'(keep_n);
    assign bytes_last = bytes_sum[16] ? 16'hFFFF : bytes_sum[15:0];

    always_comb begin
        state_nxt    = state;
        idle_nxt     = idle_cnt;
        byte_nxt     = byte_cnt;
        data_nxt     = IDLE_WORD;
        ctrl_nxt     = CTRL_ALL;
        done_nxt     = 1'b0;
        underrun_nxt = 1'b0;
        bytes_nxt    = o_frame_bytes;

        case (state)
            ST_IDLE: begin
                // The source is not consumed here; the first payload word
                // is taken in DATA, one cycle after the start word.
                if (i_s_valid && (idle_cnt >= MIN_IPG)) begin
                    data_nxt  = START_WORD;
                    ctrl_nxt  = START_CTRL;
                    byte_nxt  = '0;
                    state_nxt = ST_DATA;
                end else begin
                    idle_nxt = idle_step;
                end
            end

            ST_DATA: begin
                if (!i_s_valid) begin
                    data_nxt     = ERROR_WORD;
                    underrun_nxt = 1'b1;
                    idle_nxt     = '0;
                    state_nxt    = ST_DRAIN;
                end else if (!i_s_last || (int'(keep_n) == LANES)) begin
                    // Full word; a full last word pushes TERM into the next one.
                    data_nxt = i_s_data;
                    ctrl_nxt = CTRL_NONE;
                    byte_nxt = byte_step;
                    if (i_s_last) begin
                        state_nxt = ST_TERM;
                    end
                end else begin
                    data_nxt  = term_data;
                    ctrl_nxt  = term_ctrl;
                    idle_nxt  = IDLE_TAIL - 8'(keep_n);
                    done_nxt  = 1'b1;
                    bytes_nxt = bytes_last;
                    state_nxt = ST_IDLE;
                end
            end

            ST_TERM: begin
                data_nxt  = TERM_WORD;
                idle_nxt  = IDLE_TAIL;
                done_nxt  = 1'b1;
                bytes_nxt = byte_cnt;
                state_nxt = ST_IDLE;
            end

            ST_DRAIN: begin
                idle_nxt = idle_step;
                if (i_s_valid && i_s_last) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            idle_cnt      <= 8'hFF;
            byte_cnt      <= '0;
            o_tx_data     <= IDLE_WORD;
            o_tx_ctrl     <= CTRL_ALL;
            o_frame_done  <= 1'b0;
            o_underrun    <= 1'b0;
            o_frame_bytes <= '0;
        end else begin
            state         <= state_nxt;
            idle_cnt      <= idle_nxt;
            byte_cnt      <= byte_nxt;
            o_tx_data     <= data_nxt;
            o_tx_ctrl     <= ctrl_nxt;
            o_frame_done  <= done_nxt;
            o_underrun    <= underrun_nxt;
            o_frame_bytes <= bytes_nxt;
        end
    end

endmodule
